// File: rtl/vram_flag_painter.sv
// 256x8 video RAM with a zero-latency scan-out read port, a host write port,
// and a sequencer that paints one of four flag images into the upper half.
module vram_flag_painter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vaddr,
  output logic [DATA_W-1:0] vdata,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic [5:0]        fill_color,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAINT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [6:0]        r_cnt;
  logic [1:0]        r_sel;
  logic [5:0]        r_color;
  logic              r_wr_err;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic [3:0]        w_col;
  logic [2:0]        w_row;
  logic [DATA_W-1:0] w_px;
  logic              w_paint_we;
  logic              w_host_we;

  assign w_col = r_cnt[6:3];
  assign w_row = r_cnt[2:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PAINT;
      S_PAINT: if (r_cnt == 7'd127) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_px = '0;
    case (r_sel)
      2'd0: begin
        if (w_col <= 4'd3)      w_px = DATA_W'(8'h03);
        else if (w_col <= 4'd6) w_px = DATA_W'(8'h3F);
        else if (w_col <= 4'd9) w_px = DATA_W'(8'h30);
        else                    w_px = DATA_W'(8'h00);
      end
      2'd1: begin
        if (w_row <= 3'd2)      w_px = DATA_W'(8'h30);
        else if (w_row <= 3'd4) w_px = DATA_W'(8'h3F);
        else                    w_px = DATA_W'(8'h0C);
      end
      2'd2:    w_px = (w_col[0] ^ w_row[0]) ? DATA_W'(8'h3F) : DATA_W'(8'h00);
      default: w_px = DATA_W'({2'b00, r_color});
    endcase
  end

  // A reset edge in the middle of a paint suppresses that edge's tile write.
  assign w_paint_we = (r_state == S_PAINT) && !reset;
  assign w_host_we  = host_we && (r_state != S_PAINT);

  always_ff @(posedge clk) begin
    if (w_paint_we)
      r_mem[ADDR_W'({1'b1, r_cnt})] <= w_px;
    else if (w_host_we)
      r_mem[host_addr] <= host_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_color  <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_err <= host_we && (r_state == S_PAINT);
      if (r_state == S_IDLE && start) begin
        r_sel   <= pattern_sel;
        r_color <= fill_color;
        r_cnt   <= '0;
      end else if (r_state == S_PAINT) begin
        r_cnt <= r_cnt + 7'd1;
      end
    end
  end

  // Handshake: start is a level sampled only in IDLE; busy covers exactly the
  // paint edges, done and wr_err are single-cycle pulses.
  assign vdata     = r_mem[vaddr];
  assign busy      = (r_state == S_PAINT);
  assign done      = (r_state == S_DONE);
  assign wr_err    = r_wr_err;
  assign state_dbg = r_state;

endmodule
